cordic_vec_atan2: RTL and testbench

//  Pipelined CORDIC in vectoring mode: takes a signed I/Q sample (x,y) and returns its phase in the
//  DDS 20-bit phase format (2^20 = full circle, [19:18] = quadrant) and its magnitude. Inverse of the
//  sin/cos generator. Sits after the DDS mixer as phase detector / envelope for the NCO tracking loop.

---
 rtl/cordic_vec_atan2_if.sv | 21 ++
 rtl/cordic_vec_atan2.sv | 186 ++++++++++++++++++
 tb/tb_cordic_vec_atan2.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vec_atan2_if.sv
// rtl/cordic_vec_atan2_if.sv - I/Q sample in, phase/magnitude out bus for cordic_vec_atan2
interface cordic_vec_atan2_if #(
  parameter int IN_WIDTH = 16
);
  logic                       in_valid;
  logic signed [IN_WIDTH-1:0] x_i;
  logic signed [IN_WIDTH-1:0] y_i;
  logic                       out_valid;
  logic [19:0]                phase_o;
  logic [IN_WIDTH:0]          mag_o;

  modport master (
    output in_valid, x_i, y_i,
    input  out_valid, phase_o, mag_o
  );

  modport slave (
    input  in_valid, x_i, y_i,
    output out_valid, phase_o, mag_o
  );
endinterface

// File: rtl/cordic_vec_atan2.sv
// rtl/cordic_vec_atan2.sv - pipelined vectoring-mode CORDIC returning 20-bit phase and magnitude
// MAG_GAIN_COMP_EN adds a K-multiplier stage that removes the CORDIC gain from mag_o.
module cordic_vec_atan2 #(
  parameter int IN_WIDTH      = 16,
  parameter int GUARD         = 4,
  parameter int ITERATION_NUM = 16
`ifdef MAG_GAIN_COMP_EN
  ,
  parameter logic [15:0] K    = 16'h4DBA
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  cordic_vec_atan2_if.slave bus
);

  localparam int W  = IN_WIDTH + GUARD + 2;
  localparam int N  = ITERATION_NUM;
  localparam int MW = IN_WIDTH + 1;

  // atan(2^-i) in phase units where 2^20 is a full turn
  function automatic logic [19:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 20'd131072;
      1:       atan_lut = 20'd77376;
      2:       atan_lut = 20'd40884;
      3:       atan_lut = 20'd20753;
      4:       atan_lut = 20'd10417;
      5:       atan_lut = 20'd5213;
      6:       atan_lut = 20'd2607;
      7:       atan_lut = 20'd1304;
      8:       atan_lut = 20'd652;
      9:       atan_lut = 20'd326;
      10:      atan_lut = 20'd163;
      11:      atan_lut = 20'd81;
      12:      atan_lut = 20'd41;
      13:      atan_lut = 20'd20;
      14:      atan_lut = 20'd10;
      15:      atan_lut = 20'd5;
      default: atan_lut = 20'd0;
    endcase
  endfunction

  logic signed [W-1:0] x_q [0:N];
  logic signed [W-1:0] y_q [0:N];
  logic [19:0]         z_q [0:N];
  logic signed [W-1:0] x_d [0:N];
  logic signed [W-1:0] y_d [0:N];
  logic [19:0]         z_d [0:N];
  logic [N:0]          vld_q;
  logic [N:0]          zero_q;

  logic signed [W-1:0] x_ext;
  logic signed [W-1:0] y_ext;

  assign x_ext = {{(W-IN_WIDTH){bus.x_i[IN_WIDTH-1]}}, bus.x_i} <<< GUARD;
  assign y_ext = {{(W-IN_WIDTH){bus.y_i[IN_WIDTH-1]}}, bus.y_i} <<< GUARD;

  always_comb begin
    // Left half-plane is folded into the right half by a 180 degree pre-rotation
    x_d[0] = x_ext;
    y_d[0] = y_ext;
    z_d[0] = 20'h00000;
    if (bus.x_i[IN_WIDTH-1]) begin
      x_d[0] = -x_ext;
      y_d[0] = -y_ext;
      z_d[0] = 20'h80000;
    end
    for (int i = 1; i <= N; i++) begin
      if (!y_q[i-1][W-1]) begin
        x_d[i] = x_q[i-1] + (y_q[i-1] >>> (i-1));
        y_d[i] = y_q[i-1] - (x_q[i-1] >>> (i-1));
        z_d[i] = z_q[i-1] + atan_lut(i-1);
      end else begin
        x_d[i] = x_q[i-1] - (y_q[i-1] >>> (i-1));
        y_d[i] = y_q[i-1] + (x_q[i-1] >>> (i-1));
        z_d[i] = z_q[i-1] - atan_lut(i-1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= N; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      vld_q  <= '0;
      zero_q <= '0;
    end else begin
      for (int i = 0; i <= N; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
        z_q[i] <= z_d[i];
      end
      vld_q  <= {vld_q[N-1:0], bus.in_valid};
      zero_q <= {zero_q[N-1:0], (bus.x_i == '0) && (bus.y_i == '0)};
    end
  end

  logic signed [W-1:0] fin_x;
  logic [19:0]         fin_z;
  logic                fin_vld;
  logic                fin_zero;

`ifdef MAG_GAIN_COMP_EN
  localparam int PW = W + 17;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_rnd;
  logic signed [W-1:0]  gx_q;
  logic [19:0]          gz_q;
  logic                 gvld_q;
  logic                 gzero_q;

  always_comb begin
    prod     = PW'(x_q[N]) * PW'(signed'({1'b0, K}));
    prod_rnd = (prod + (PW'(1) <<< 14)) >>> 15;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q    <= '0;
      gz_q    <= '0;
      gvld_q  <= 1'b0;
      gzero_q <= 1'b0;
    end else begin
      gx_q    <= prod_rnd[W-1:0];
      gz_q    <= z_q[N];
      gvld_q  <= vld_q[N];
      gzero_q <= zero_q[N];
    end
  end

  assign fin_x    = gx_q;
  assign fin_z    = gz_q;
  assign fin_vld  = gvld_q;
  assign fin_zero = gzero_q;
`else
  assign fin_x    = x_q[N];
  assign fin_z    = z_q[N];
  assign fin_vld  = vld_q[N];
  assign fin_zero = zero_q[N];
`endif

  localparam logic signed [W-1:0] MAG_MAX = W'((1 << MW) - 1);

  logic signed [W-1:0] mag_full;
  logic [MW-1:0]       mag_d;
  logic [19:0]         phase_d;
  logic                out_valid_q;
  logic [19:0]         phase_q;
  logic [MW-1:0]       mag_q;

  // A zero vector would otherwise report the accumulated sum of all micro-rotations
  always_comb begin
    mag_full = fin_x >>> GUARD;
    mag_d    = mag_full[MW-1:0];
    if (mag_full < 0) begin
      mag_d = '0;
    end else if (mag_full > MAG_MAX) begin
      mag_d = '1;
    end
    phase_d = fin_zero ? 20'h00000 : fin_z;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      phase_q     <= '0;
      mag_q       <= '0;
    end else begin
      out_valid_q <= fin_vld;
      if (fin_vld) begin
        phase_q <= phase_d;
        mag_q   <= mag_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.phase_o   = phase_q;
  assign bus.mag_o     = mag_q;

endmodule

// File: tb/tb_cordic_vec_atan2.sv
// tb/tb_cordic_vec_atan2.sv - scoreboard bench for cordic_vec_atan2 against a real-valued atan2 model
module tb_cordic_vec_atan2;

  localparam int  IN_WIDTH = 16;
  localparam int  ITER     = 16;
`ifdef MAG_GAIN_COMP_EN
  localparam int  LAT      = ITER + 3;
  localparam real GAIN     = 1.0;
`else
  localparam int  LAT      = ITER + 2;
  localparam real GAIN     = 1.6467602;
`endif
  localparam real PI       = 3.14159265358979;

  typedef struct {
    int          x;
    int          y;
    logic [19:0] ph;
    int          mag;
    int          ptol;
    int          mtol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_checks = 0;
  exp_t sb_q[$];

  cordic_vec_atan2_if #(.IN_WIDTH(IN_WIDTH)) bus ();

  cordic_vec_atan2 #(
    .IN_WIDTH(IN_WIDTH),
    .GUARD(4),
    .ITERATION_NUM(ITER)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    real  p;
    int   pi_int;
    p      = $atan2(real'(y), real'(x)) * 1048576.0 / (2.0 * PI);
    pi_int = int'(p);
    e.x    = x;
    e.y    = y;
    e.ph   = 20'(pi_int);
    e.mag  = int'(GAIN * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
    e.ptol = (x == 0 && y == 0) ? 0 : 16;
    e.mtol = (x == 0 && y == 0) ? 0 : 8;
    return e;
  endfunction

  function automatic int ph_err(input logic [19:0] got, input logic [19:0] want);
    logic [19:0] d;
    d = got - want;
    return d[19] ? 1048576 - int'(d) : int'(d);
  endfunction

  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // One cycle: sample outputs at the negedge, pop the matching expectation, then drive the next input
  task automatic tick(input logic v, input int x, input int y, output logic got, output logic had,
                      output exp_t e, output logic [19:0] ph, output logic [IN_WIDTH:0] mg);
    @(negedge clk);
    got = bus.out_valid;
    ph  = bus.phase_o;
    mg  = bus.mag_o;
    had = 1'b0;
    e   = '{default: 0};
    if (got && sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      had = 1'b1;
    end
    bus.in_valid = v;
    bus.x_i      = 16'(x);
    bus.y_i      = 16'(y);
    if (v) sb_q.push_back(model(x, y));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.phase_o !== 20'h0) $display("FAIL reset_phase: got %h, required 00000", bus.phase_o);
    else n_pass++;
    n_checks++;
    if (bus.mag_o !== '0) $display("FAIL reset_mag: got %0d, required 0", bus.mag_o);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic got, had;
    exp_t e;
    logic [19:0] ph;
    logic [IN_WIDTH:0] mg;
    int lat = -1;
    int nout = 0;
    tick(1'b1, 16384, 0, got, had, e, ph, mg);
    for (int k = 1; k <= LAT + 4; k++) begin
      tick(1'b0, 0, 0, got, had, e, ph, mg);
      if (got) begin
        nout++;
        if (nout == 1) lat = k;
        n_checks++;
        if (!had || ph_err(ph, e.ph) > e.ptol || abs_diff(int'(mg), e.mag) > e.mtol)
          $display("FAIL latency_value: got phase=%h mag=%0d, required phase=%h mag=%0d", ph, mg, e.ph, e.mag);
        else n_pass++;
      end
    end
    n_checks++;
    if (lat !== LAT) $display("FAIL latency_cycles: got %0d, required %0d", lat, LAT);
    else n_pass++;
    n_checks++;
    if (nout !== 1) $display("FAIL latency_pulse_count: got %0d, required 1", nout);
    else n_pass++;
  endtask

  task automatic test_directed();
    int dx [9] = '{16384, 0, -16384, 0, 11585, -32768, 0, 32767, -32768};
    int dy [9] = '{0, 16384, 0, -16384, 11585, -32768, 0, -32768, 32767};
    logic got, had;
    exp_t e;
    logic [19:0] ph;
    logic [IN_WIDTH:0] mg;
    for (int k = 0; k < 9 + LAT + 3; k++) begin
      if (k < 9) tick(1'b1, dx[k], dy[k], got, had, e, ph, mg);
      else       tick(1'b0, 0, 0, got, had, e, ph, mg);
      if (got) begin
        n_checks++;
        if (!had)
          $display("FAIL directed_spurious: got out_valid with phase=%h, required no output", ph);
        else if (ph_err(ph, e.ph) > e.ptol || abs_diff(int'(mg), e.mag) > e.mtol)
          $display("FAIL directed[x=%0d,y=%0d]: got phase=%h mag=%0d, required phase=%h+/-%0d mag=%0d+/-%0d",
                   e.x, e.y, ph, mg, e.ph, e.ptol, e.mag, e.mtol);
        else n_pass++;
      end
    end
    n_checks++;
    if (sb_q.size() !== 0) $display("FAIL directed_drain: got %0d outstanding, required 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_hold();
    logic got, had;
    exp_t e, held;
    logic [19:0] ph;
    logic [IN_WIDTH:0] mg;
    int seen = 0;
    int bad = 0;
    held = '{default: 0};
    tick(1'b1, -20000, 9000, got, had, e, ph, mg);
    for (int k = 0; k < LAT + 3; k++) begin
      tick(1'b0, 0, 0, got, had, e, ph, mg);
      if (got) begin
        seen++;
        held = e;
      end
    end
    n_checks++;
    if (seen !== 1 || ph_err(ph, held.ph) > 16 || abs_diff(int'(mg), held.mag) > 8)
      $display("FAIL hold_setup: got %0d outputs phase=%h mag=%0d, required 1 output phase=%h mag=%0d",
               seen, ph, mg, held.ph, held.mag);
    else n_pass++;
    for (int k = 0; k < 50; k++) begin
      tick(1'b0, 0, 0, got, had, e, ph, mg);
      if (got || ph_err(ph, held.ph) > 16 || abs_diff(int'(mg), held.mag) > 8) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL hold_idle: got %0d disturbed cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_midstream_reset();
    logic got, had;
    exp_t e;
    logic [19:0] ph;
    logic [IN_WIDTH:0] mg;
    int stale = 0;
    for (int k = 0; k < 5; k++) tick(1'b1, 5000 + 1000 * k, -3000, got, had, e, ph, mg);
    tick(1'b0, 0, 0, got, had, e, ph, mg);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b, required 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.phase_o !== 20'h0) $display("FAIL async_reset_phase: got %h, required 00000", bus.phase_o);
    else n_pass++;
    n_checks++;
    if (bus.mag_o !== '0) $display("FAIL async_reset_mag: got %0d, required 0", bus.mag_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    for (int k = 0; k < LAT + 6; k++) begin
      tick(1'b0, 0, 0, got, had, e, ph, mg);
      if (got) stale++;
    end
    n_checks++;
    if (stale !== 0) $display("FAIL reset_stale_valid: got %0d pulses, required 0", stale);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic got, had, v;
    exp_t e;
    logic [19:0] ph;
    logic [IN_WIDTH:0] mg;
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    int x, y;
    while ((sent < 1000 || sb_q.size() > 0) && cyc < 6000) begin
      v = (sent < 1000) && ($urandom_range(3) != 0);
      x = 0;
      y = 0;
      if (v) begin
        do begin
          x = int'($signed(16'($urandom)));
          y = int'($signed(16'($urandom)));
        end while (longint'(x) * x + longint'(y) * y < 64'd16777216);
      end
      tick(v, x, y, got, had, e, ph, mg);
      cyc++;
      if (v) sent++;
      if (got) begin
        rcv++;
        n_checks++;
        if (!had)
          $display("FAIL stream_spurious: got out_valid with phase=%h, required no output", ph);
        else if (ph_err(ph, e.ph) > e.ptol || abs_diff(int'(mg), e.mag) > e.mtol)
          $display("FAIL stream[x=%0d,y=%0d]: got phase=%h mag=%0d, required phase=%h+/-%0d mag=%0d+/-%0d",
                   e.x, e.y, ph, mg, e.ph, e.ptol, e.mag, e.mtol);
        else n_pass++;
      end
    end
    n_checks++;
    if (rcv !== 1000) $display("FAIL stream_count: got %0d outputs, required 1000", rcv);
    else n_pass++;
    n_checks++;
    if (sb_q.size() !== 0) $display("FAIL stream_drain: got %0d outstanding, required 0", sb_q.size());
    else n_pass++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.x_i      = '0;
    bus.y_i      = '0;
    test_reset();
    test_latency();
    test_directed();
    test_hold();
    test_midstream_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
